// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clkdiv_ctrl clock divider.
package clkdiv_pkg;

  localparam int WIDTH_DEF       = 32;
  localparam int DEFAULT_DIV_DEF = 50000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

endpackage

// File: rtl/clkdiv_cfg_if.sv
// Divisor-update handshake between a configuration master and clkdiv_ctrl.
interface clkdiv_cfg_if
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  // A transfer happens on a rising clk edge where cfg_valid && cfg_ready.
  // The master may hold cfg_valid high; cfg_div must stay stable while it does.
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);

endinterface

// File: rtl/clkdiv_core.sv
// Half-period counter with terminal detect, divided-clock toggle and divisor register.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic             terminal_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             clk_div_q, clk_div_d;

  // active_q is never zero, so the subtraction cannot underflow.
  assign terminal_o = (count_q == (active_q - WIDTH'(1)));
  assign tick_o     = enable_i && terminal_o;
  assign clk_div_o  = clk_div_q;

  always_comb begin
    count_d   = count_q;
    clk_div_d = clk_div_q;
    active_d  = active_q;
    if (enable_i) begin
      if (terminal_o) begin
        count_d   = '0;
        clk_div_d = ~clk_div_q;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
    if (clear_i) begin
      count_d = '0;
    end
    if (load_i) begin
      active_d = load_val_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      active_q  <= WIDTH'(DEFAULT_DIV);
      clk_div_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      clk_div_q <= clk_div_d;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run/stop FSM and divisor-update handshake around the clkdiv_core counter.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic         clk,
  input  logic         rst,
  clkdiv_cfg_if.slave  cfg,
  input  logic         start,
  input  logic         stop,
  output logic         clk_div,
  output logic         tick,
  output logic         running,
  output logic         cfg_err,
  output state_e       state_o
);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             cfg_err_q, cfg_err_d;
  logic             core_en, core_clr, core_load, terminal, capture;

  assign cfg.cfg_ready = !pending_q;
  assign capture       = cfg.cfg_valid && !pending_q;
  assign running       = (state_q != ST_IDLE);
  assign cfg_err       = cfg_err_q;
  assign state_o       = state_q;

  // While dividing, a new divisor only takes effect on a half-period boundary.
  assign core_load = pending_q && ((state_q == ST_IDLE) || (core_en && terminal));

  always_comb begin
    state_d  = state_q;
    core_en  = 1'b0;
    core_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        core_en = 1'b1;
        if (stop) begin
          if (!clk_div) begin
            core_en  = 1'b0;
            core_clr = 1'b1;
            state_d  = ST_IDLE;
          end else if (terminal) begin
            core_clr = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_STOPPING;
          end
        end
      end
      ST_STOPPING: begin
        core_en = 1'b1;
        if (terminal) begin
          core_clr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pending_d  = pending_q;
    pend_div_d = pend_div_q;
    cfg_err_d  = 1'b0;
    if (core_load) begin
      pending_d = 1'b0;
    end
    if (capture) begin
      if (cfg.cfg_div == '0) begin
        cfg_err_d = 1'b1;
      end else begin
        pending_d  = 1'b1;
        pend_div_d = cfg.cfg_div;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      pend_div_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_div_q <= pend_div_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  clkdiv_core #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_core (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (core_en),
    .clear_i    (core_clr),
    .load_i     (core_load),
    .load_val_i (pend_div_q),
    .clk_div_o  (clk_div),
    .tick_o     (tick),
    .terminal_o (terminal)
  );

endmodule
